riscv_mem_responder: RTL and testbench
======================================

// Module: riscv_mem_responder
// PURPOSE
//   Memory-side responder for the riscv_core instruction and data buses.
//   Serves instruction fetches and byte/half/word data loads and stores from an on-chip word array.
//   Each request gets a 1-cycle registered response, with lane alignment and access checking.
//   Sits beside riscv_core in the SoC top and in the core testbench as the memory model.
// PARAMETERS
//   MEM_WORDS  1024           array depth in 32-bit words (4 KiB, covers RESET_SP 0x1000)
//   ADDR_BASE  32'h0000_0000  byte address of word 0
//   MMIO_ADDR  32'hFFFF_FFF0  byte address of the tx register (RISCV_MEM_MMIO_EN only)
// PORTS
//   clk_i       in   1   clock
//   reset_i     in   1   asynchronous reset, active-high
//   iaddr_i     in   32  fetch byte address (word-aligned; bits [1:0] ignored)
//   ird_i       in   1   fetch request
//   irdata_o    out  32  fetch data, valid the cycle after ird_i; held until the next ird_i
//   daddr_i     in   32  data byte address
//   dwdata_i    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   dsize_i     in   2   `SIZE_BYTE / `SIZE_HALF / `SIZE_WORD (riscv_defines.v)
//   drd_i       in   1   load request
//   dwr_i       in   1   store request
//   drdata_o    out  32  load data, right-aligned and zero-extended; core applies sign extension
//   err_o       out  1   sticky access error
//   err_addr_o  out  32  address of the first erroring access
//   tx_data_o   out  8   last byte written to MMIO_ADDR
//   tx_valid_o  out  1   1-cycle pulse per MMIO write
// BEHAVIOUR
// - Reset: all outputs 0 (irdata_o, drdata_o, err_o, err_addr_o, tx_data_o, tx_valid_o).
//   - Array contents are not reset and are kept across reset.
//   - A store sampled on the reset edge is dropped.
// - Fetch port:
//   - On a clock edge with ird_i=1: irdata_o <= mem[(iaddr_i-ADDR_BASE)>>2].
//   - ird_i=0: irdata_o holds. The core decodes from the held word between fetches.
//   - Fetch out of range: irdata_o <= 0, err set.
// - Load (drd_i=1, dwr_i=0):
//   - Edge: drdata_o <= selected lanes shifted to bit 0, upper bits 0.
//   - Byte lane = daddr_i[1:0]. Half lane = daddr_i[1] (offset 0 or 16).
//   - drd_i=0: drdata_o holds.
//   - Latency is exactly 1 cycle, matching the core's single mem-stall cycle.
// - Store (dwr_i=1):
//   - Byte-enable write on the edge.
//   - Byte enables: BYTE 0001<<a[1:0], HALF 0011<<{a[1],1'b0}, WORD 1111.
//   - dwdata_i is replicated into the lanes (byte x4, half x2).
//   - drd_i and dwr_i both high: the write executes, the read is ignored, and drdata_o holds.
// - Dual-port collisions:
//   - A fetch and a store to the same word in the same cycle: the fetch returns the OLD word (read-before-write).
//   - A load reads the array only, so a load never collides with a store.
// - Errors:
//   - Misaligned: HALF with a[0]=1, or WORD with a[1:0]!=0. Also out of range: word index >= MEM_WORDS or address < ADDR_BASE.
//   - On error the access is suppressed: no write; the read returns 0 on the data port. Fetch errors behave as above.
//   - err_o sets on the first error and stays set until reset.
//   - err_addr_o latches the address of the first error only.
//   - Data and fetch errors in the same cycle: the data address is recorded.
// - Address arithmetic: word index = (addr-ADDR_BASE)[31:2]. It is unsigned, so addr < ADDR_BASE wraps and is caught as out of range.
// CONFIGURATION
// - RISCV_MEM_MMIO_EN defined:
//   - A store to MMIO_ADDR (any size, aligned) does not touch the array.
//   - It sets tx_data_o <= dwdata_i[7:0], and tx_valid_o=1 for exactly the next cycle.
//   - A load from MMIO_ADDR returns {24'h0, tx_data_o}.
// - RISCV_MEM_MMIO_EN undefined:
//   - tx_data_o and tx_valid_o are tied to 0.
//   - MMIO_ADDR is an ordinary address, normally out of range, so it errors.
// STRUCTURE
// - Shared package riscv_defines.v: uses the existing SIZE_* encodings.
//   - Add RISCV_MEM_MMIO_ADDR_DEFAULT.
//   - Add a byte-enable function be_from_size(size, addr[1:0]).
// - Sub-module riscv_mem_array: 2-port synchronous RAM with write port A and read port B.
//   - Write port A has 4 byte enables.
//   - Read port B is used by fetch and load.
//   - It provides read-before-write semantics.
// - riscv_mem_responder keeps these: port arbitration, lane alignment, error/MMIO logic, and output hold registers.
// TESTING
// - Word store 0x100 <= 0xDEADBEEF, then load word 0x100 -> drdata_o=0xDEADBEEF one cycle after drd_i.
// - Load byte 0x103 -> 0x000000DE. Load half 0x102 -> 0x0000DEAD.
// - Store byte 0x101 <= 0x55 -> word 0x100 reads 0xDEAD55EF.
// - Fetch ird_i at 0x100, then ird_i=0 for 3 cycles -> irdata_o=0xDEAD55EF, stable all 3 cycles.
// - Same cycle: fetch 0x200 plus store word 0x200 <= 0x12345678.
//   - Expect the old word on irdata_o.
//   - The next fetch returns 0x12345678.
// - Error checks:
//   - Load half 0x101 -> drdata_o=0, err_o=1, err_addr_o=0x101.
//   - A later store word to 0x5000 (out of range) -> no write, err_addr_o stays 0x101.
// - RISCV_MEM_MMIO_EN: store byte 0x41 to 0xFFFFFFF0.
//   - Expect tx_valid_o high for 1 cycle, tx_data_o=0x41, err_o=0.
//   - Assert reset_i mid-burst -> all outputs 0 and memory preserved.

Source files
------------

// File: rtl/riscv_mem_responder_pkg.sv
// Shared types and helpers for the riscv_mem_responder memory model.
// Size encodings, MMIO default address, byte-enable and lane helpers.
package riscv_mem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] RISCV_MEM_MMIO_ADDR_DEFAULT = 32'hFFFF_FFF0;

  function automatic logic [3:0] be_from_size(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << a;
      SIZE_HALF: be = 4'b0011 << {a[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic m;
    case (size)
      SIZE_BYTE: m = 1'b0;
      SIZE_HALF: m = a[0];
      default:   m = (a != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_rep(
    input logic [1:0]  size,
    input logic [31:0] wd
  );
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {4{wd[7:0]}};
      SIZE_HALF: r = {2{wd[15:0]}};
      default:   r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_get(
    input logic [1:0]  size,
    input logic [1:0]  a,
    input logic [31:0] w
  );
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {24'h0, w[{a, 3'b000} +: 8]};
      SIZE_HALF: r = {16'h0, w[{a[1], 4'h0} +: 16]};
      default:   r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Core-to-memory bus: fetch port, data port and MMIO tx outputs.
// Names carry the responder's point of view (_i into it, _o out).
interface riscv_mem_responder_if;

  logic [31:0] iaddr_i;
  logic        ird_i;
  logic [31:0] irdata_o;
  logic [31:0] daddr_i;
  logic [31:0] dwdata_i;
  logic [1:0]  dsize_i;
  logic        drd_i;
  logic        dwr_i;
  logic [31:0] drdata_o;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;

  modport master (
    output iaddr_i, ird_i,
    output daddr_i, dwdata_i, dsize_i,
    output drd_i, dwr_i,
    input  irdata_o, drdata_o,
    input  err_o, err_addr_o,
    input  tx_data_o, tx_valid_o
  );

  modport slave (
    input  iaddr_i, ird_i,
    input  daddr_i, dwdata_i, dsize_i,
    input  drd_i, dwr_i,
    output irdata_o, drdata_o,
    output err_o, err_addr_o,
    output tx_data_o, tx_valid_o
  );

endinterface

// File: rtl/riscv_mem_array.sv
// Synchronous word RAM: byte-enabled write port A, read port B with
// fetch and data taps. Reads return the pre-write word on collision.
module riscv_mem_array #(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_f_i,
  input  logic [AW-1:0] raddr_d_i,
  output logic [31:0]   rdata_f_o,
  output logic [31:0]   rdata_d_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_f_q;
  logic [31:0] rdata_d_q;

  always_ff @(posedge clk_i) begin
    rdata_f_q <= mem_q[raddr_f_i];
    rdata_d_q <= mem_q[raddr_d_i];
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_f_o = rdata_f_q;
  assign rdata_d_o = rdata_d_q;

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory responder for riscv_core fetch/data buses, 1-cycle latency.
// Build with RISCV_MEM_MMIO_EN to enable the tx register at MMIO_ADDR.
module riscv_mem_responder
  import riscv_mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] MMIO_ADDR = RISCV_MEM_MMIO_ADDR_DEFAULT
) (
  input logic                  clk_i,
  input logic                  reset_i,
  riscv_mem_responder_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);

`ifdef RISCV_MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic [29:0] f_idx;
  logic [29:0] d_idx;
  logic        f_oor;
  logic        d_oor;
  logic        d_mis;
  logic        mmio_hit;
  logic        d_err;
  logic        f_err;
  logic        d_ld;
  logic        st_we;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [31:0] arr_f;
  logic [31:0] arr_d;

  logic        fvld_q, fvld_d;
  logic [31:0] irdata_q, irdata_d;
  logic        dvld_q, dvld_d;
  logic [1:0]  dsize_q, dsize_d;
  logic [1:0]  dlane_q, dlane_d;
  logic [31:0] drdata_q, drdata_d;
  logic        err_q, err_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;

  // Unsigned offset: addresses below ADDR_BASE wrap and read as out of range
  assign f_idx = 30'((bus.iaddr_i - ADDR_BASE) >> 2);
  assign d_idx = 30'((bus.daddr_i - ADDR_BASE) >> 2);
  assign f_oor = ({2'b00, f_idx} >= 32'(MEM_WORDS));
  assign d_oor = ({2'b00, d_idx} >= 32'(MEM_WORDS));

  assign d_mis    = misaligned(bus.dsize_i, bus.daddr_i[1:0]);
  assign mmio_hit = MMIO_EN && (bus.daddr_i == MMIO_ADDR) && !d_mis;
  assign d_err    = (bus.drd_i | bus.dwr_i)
                  & (d_mis | (d_oor & ~mmio_hit));
  assign f_err    = bus.ird_i & f_oor;
  assign d_ld     = bus.drd_i & ~bus.dwr_i;

  assign st_we = bus.dwr_i & ~d_err & ~mmio_hit & ~reset_i;
  assign st_be = be_from_size(bus.dsize_i, bus.daddr_i[1:0]);
  assign st_wd = lane_rep(bus.dsize_i, bus.dwdata_i);

  riscv_mem_array #(
    .WORDS(MEM_WORDS)
  ) u_array (
    .clk_i     (clk_i),
    .we_i      (st_we),
    .be_i      (st_be),
    .waddr_i   (d_idx[AW-1:0]),
    .wdata_i   (st_wd),
    .raddr_f_i (f_idx[AW-1:0]),
    .raddr_d_i (d_idx[AW-1:0]),
    .rdata_f_o (arr_f),
    .rdata_d_o (arr_d)
  );

  always_comb begin
    fvld_d   = 1'b0;
    irdata_d = fvld_q ? arr_f : irdata_q;
    if (bus.ird_i) begin
      if (f_err) irdata_d = '0;
      else       fvld_d   = 1'b1;
    end

    dvld_d   = 1'b0;
    dsize_d  = dsize_q;
    dlane_d  = dlane_q;
    drdata_d = dvld_q ? lane_get(dsize_q, dlane_q, arr_d)
                      : drdata_q;
    if (d_ld) begin
      if (d_err) begin
        drdata_d = '0;
      end else if (mmio_hit) begin
        drdata_d = {24'h0, tx_data_q};
      end else begin
        dvld_d  = 1'b1;
        dsize_d = bus.dsize_i;
        dlane_d = bus.daddr_i[1:0];
      end
    end

    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    if (bus.dwr_i && mmio_hit) begin
      tx_data_d  = bus.dwdata_i[7:0];
      tx_valid_d = 1'b1;
    end

    // First error wins; the data address beats a same-cycle fetch error
    err_d   = err_q | d_err | f_err;
    eaddr_d = eaddr_q;
    if (!err_q) begin
      if (d_err)      eaddr_d = bus.daddr_i;
      else if (f_err) eaddr_d = bus.iaddr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fvld_q     <= 1'b0;
      irdata_q   <= '0;
      dvld_q     <= 1'b0;
      dsize_q    <= SIZE_WORD;
      dlane_q    <= 2'b00;
      drdata_q   <= '0;
      err_q      <= 1'b0;
      eaddr_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      fvld_q     <= fvld_d;
      irdata_q   <= irdata_d;
      dvld_q     <= dvld_d;
      dsize_q    <= dsize_d;
      dlane_q    <= dlane_d;
      drdata_q   <= drdata_d;
      err_q      <= err_d;
      eaddr_q    <= eaddr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign bus.irdata_o   = fvld_q ? arr_f : irdata_q;
  assign bus.drdata_o   = dvld_q ? lane_get(dsize_q, dlane_q, arr_d)
                                 : drdata_q;
  assign bus.err_o      = err_q;
  assign bus.err_addr_o = eaddr_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.tx_valid_o = tx_valid_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Scoreboard bench for riscv_mem_responder with a word-array reference.
// Define RISCV_MEM_MMIO_EN for both DUT and bench to cover the tx path.
module tb_riscv_mem_responder;
  import riscv_mem_responder_pkg::*;

  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] MMIO = 32'hFFFF_FFF0;
`ifdef RISCV_MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_mem_responder_if bus();

  riscv_mem_responder dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] dr;
    logic        e;
    logic [31:0] ea;
    logic [7:0]  tx;
    logic        txv;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  logic [31:0] mm [1024];
  logic [31:0] m_ir, m_dr, m_ea;
  logic        m_e, m_txv;
  logic [7:0]  m_tx;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("irdata", bus.irdata_o, me.ir);
      chk("drdata", bus.drdata_o, me.dr);
      chk("err", 32'(bus.err_o), 32'(me.e));
      chk("err_addr", bus.err_addr_o, me.ea);
      chk("tx_data", 32'(bus.tx_data_o), 32'(me.tx));
      chk("tx_valid", 32'(bus.tx_valid_o), 32'(me.txv));
    end
  end

  task automatic model_reset();
    m_ir = 0; m_dr = 0; m_e = 0; m_ea = 0; m_tx = 0; m_txv = 0;
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w,
      input logic [1:0] sz, input logic [1:0] a);
    if (sz == SIZE_BYTE) return (w >> (8 * a)) & 32'hFF;
    if (sz == SIZE_HALF) return (w >> (16 * a[1])) & 32'hFFFF;
    return w;
  endfunction

  task automatic cyc(input logic r, input logic fi,
      input logic [31:0] ia, input logic rd, input logic wr,
      input logic [31:0] da, input logic [31:0] wd,
      input logic [1:0] sz);
    logic [31:0] fw, dw, w;
    logic mis, hit, derr, ferr;
    exp_t e;
    @(negedge clk);
    #2;
    rst = r;
    bus.ird_i = fi; bus.iaddr_i = ia;
    bus.drd_i = rd; bus.dwr_i = wr;
    bus.daddr_i = da; bus.dwdata_i = wd; bus.dsize_i = sz;
    if (r) begin
      model_reset();
    end else begin
      fw = (ia - BASE) >> 2;
      dw = (da - BASE) >> 2;
      ferr = fi && (fw >= 1024);
      if (fi) m_ir = ferr ? 32'h0 : mm[fw[9:0]];
      mis = (sz == SIZE_HALF && da[0]) ||
            (sz == SIZE_WORD && da[1:0] != 0);
      hit = MMIO_EN && da == MMIO && !mis;
      derr = (rd || wr) && (mis || (dw >= 1024 && !hit));
      if (rd && !wr)
        m_dr = derr ? 32'h0 : hit ? {24'h0, m_tx}
             : extract(mm[dw[9:0]], sz, da[1:0]);
      m_txv = 0;
      if (wr && !derr) begin
        if (hit) begin
          m_tx = wd[7:0];
          m_txv = 1;
        end else begin
          w = mm[dw[9:0]];
          if (sz == SIZE_BYTE) w[8*da[1:0] +: 8] = wd[7:0];
          else if (sz == SIZE_HALF) w[16*da[1] +: 16] = wd[15:0];
          else w = wd;
          mm[dw[9:0]] = w;
        end
      end
      if (!m_e && (derr || ferr)) begin
        m_e = 1;
        m_ea = derr ? da : ia;
      end
    end
    e.ir = m_ir; e.dr = m_dr; e.e = m_e; e.ea = m_ea;
    e.tx = m_tx; e.txv = m_txv;
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, SIZE_WORD);
  endtask
  task automatic fetch(input logic [31:0] a);
    cyc(0, 1, a, 0, 0, 0, 0, SIZE_WORD);
  endtask
  task automatic ld(input logic [31:0] a, input logic [1:0] s);
    cyc(0, 0, 0, 1, 0, a, 0, s);
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] s);
    cyc(0, 0, 0, 0, 1, a, d, s);
  endtask

  logic [31:0] old, ia, da, wd;
  logic [1:0]  op, sz;
  int p;

  initial begin
    rst = 1;
    bus.ird_i = 0; bus.iaddr_i = 0; bus.drd_i = 0; bus.dwr_i = 0;
    bus.daddr_i = 0; bus.dwdata_i = 0; bus.dsize_i = SIZE_WORD;
    model_reset();
    #1;
    chk("rst_irdata", bus.irdata_o, 0);
    chk("rst_drdata", bus.drdata_o, 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid_o), 0);
    cyc(1, 0, 0, 0, 0, 0, 0, SIZE_WORD);
    cyc(1, 0, 0, 0, 0, 0, 0, SIZE_WORD);
    for (int i = 0; i < 160; i++) st(i * 4, $urandom, SIZE_WORD);

    st(32'h100, 32'hDEADBEEF, SIZE_WORD);
    ld(32'h100, SIZE_WORD);
    chk("ld_word", bus.drdata_o, 32'hDEADBEEF);
    ld(32'h103, SIZE_BYTE);
    chk("ld_byte", bus.drdata_o, 32'h0000_00DE);
    ld(32'h102, SIZE_HALF);
    chk("ld_half", bus.drdata_o, 32'h0000_DEAD);
    st(32'h101, 32'h55, SIZE_BYTE);
    ld(32'h100, SIZE_WORD);
    chk("st_byte", bus.drdata_o, 32'hDEAD55EF);
    fetch(32'h100);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("fetch_hold", bus.irdata_o, 32'hDEAD55EF);
    end
    old = mm[128];
    cyc(0, 1, 32'h200, 0, 1, 32'h200, 32'h12345678, SIZE_WORD);
    chk("rbw_old", bus.irdata_o, old);
    fetch(32'h200);
    chk("rbw_new", bus.irdata_o, 32'h12345678);

`ifdef RISCV_MEM_MMIO_EN
    st(MMIO, 32'h41, SIZE_BYTE);
    chk("mmio_txv", 32'(bus.tx_valid_o), 1);
    chk("mmio_txd", 32'(bus.tx_data_o), 32'h41);
    chk("mmio_err", 32'(bus.err_o), 0);
    ld(MMIO, SIZE_WORD);
    chk("mmio_txv_low", 32'(bus.tx_valid_o), 0);
    chk("mmio_ld", bus.drdata_o, 32'h41);
    st(MMIO, 32'h7A, SIZE_WORD);
`else
    fetch(32'h104);
    ld(32'h100, SIZE_WORD);
`endif

    // Asynchronous reset in the middle of a burst
    @(negedge clk);
    #2;
    rst = 1;
    bus.ird_i = 0; bus.drd_i = 0; bus.dwr_i = 0;
    model_reset();
    #1;
    chk("arst_irdata", bus.irdata_o, 0);
    chk("arst_drdata", bus.drdata_o, 0);
    chk("arst_err", 32'(bus.err_o), 0);
    chk("arst_eaddr", bus.err_addr_o, 0);
    chk("arst_txd", 32'(bus.tx_data_o), 0);
    chk("arst_txv", 32'(bus.tx_valid_o), 0);
    cyc(1, 0, 0, 0, 1, 32'h100, 32'h0, SIZE_WORD);
    ld(32'h100, SIZE_WORD);
    chk("keep_mem", bus.drdata_o, 32'hDEAD55EF);
    fetch(32'h200);
    chk("keep_fetch", bus.irdata_o, 32'h12345678);

    ld(32'h101, SIZE_HALF);
    chk("mis_data", bus.drdata_o, 0);
    chk("mis_err", 32'(bus.err_o), 1);
    chk("mis_eaddr", bus.err_addr_o, 32'h101);
    st(32'h5000, 32'hAAAA5555, SIZE_WORD);
    chk("oor_eaddr", bus.err_addr_o, 32'h101);
    st(MMIO, 32'h33, SIZE_BYTE);
    ld(32'h5000, SIZE_BYTE);

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 0) cyc(1, 0, 0, 0, 0, 0, 0, SIZE_WORD);
      ia = ($urandom_range(0, 19) == 0)
         ? 32'h5000 + $urandom_range(0, 255)
         : 32'($urandom_range(0, 32'h27F));
      op = 2'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 2));
      p = $urandom_range(0, 19);
      if (p == 0)     da = 32'h6000 + $urandom_range(0, 15);
      else if (p == 1) da = MMIO;
      else if (p < 4) da = ia;
      else            da = 32'($urandom_range(0, 32'h27F));
      wd = $urandom;
      cyc(0, 1'($urandom_range(0, 1)), ia, op[0], op[1], da, wd, sz);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
